// File: rtl/knn_uram_pkg.sv
// Shared constants and types for the local URAM port arbiter and its response FIFO.
package knn_uram_pkg;

  localparam int DefDataWidth    = 256;
  localparam int DefAddressWidth = 11;
  localparam int DefMemLatency   = 2;
  localparam int DefRespDepth    = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_t;

  typedef logic [$clog2(DefRespDepth+1)-1:0] credit_t;

endpackage

// File: rtl/knn_uram_resp_fifo.sv
// Show-ahead response FIFO holding read data returned by the URAM until the reader pops it.
module knn_uram_resp_fifo #(
  parameter int DataWidth = 256,
  parameter int Depth     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [DataWidth-1:0]         i_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [DataWidth-1:0]         o_data,
  output logic [$clog2(Depth+1)-1:0]   o_count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth+1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 w_do_pop;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= nextPtr(r_wr_ptr);
      if (w_do_pop) r_rd_ptr <= nextPtr(r_rd_ptr);
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/knn_local_uram_port_arbiter.sv
// Round-robin arbiter sharing one single-port URAM between the tile loader (writes) and the
// distance pipeline (reads), with credit-guarded buffering of read data.
module knn_local_uram_port_arbiter
  import knn_uram_pkg::*;
#(
  parameter int DataWidth    = DefDataWidth,
  parameter int AddressWidth = DefAddressWidth,
  parameter int MEM_LATENCY  = DefMemLatency,
  parameter int RESP_DEPTH   = DefRespDepth
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [AddressWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0]    i_wr_data,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready,
  input  logic [AddressWidth-1:0] i_rd_addr,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DataWidth-1:0]    o_resp_data,
  output logic [AddressWidth-1:0] o_mem_address0,
  output logic                    o_mem_ce0,
  output logic                    o_mem_we0,
  output logic [DataWidth-1:0]    o_mem_d0,
  input  logic [DataWidth-1:0]    i_mem_q0,
  output logic                    o_busy
);

  grant_t                 w_grant;
  grant_t                 r_rr_last;
  logic [MEM_LATENCY-1:0] r_inflight_sr;
  credit_t                w_inflight;
  credit_t                w_fifo_count;
  credit_t                w_used;
  credit_t                w_credits;
  logic                   w_rd_eligible;
  logic                   w_push;
  logic                   w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_inflight = w_inflight + credit_t'(r_inflight_sr[i]);
    end
  end

  // Every accepted read owns a FIFO slot from grant until pop, so capture can never overflow.
  assign w_used        = w_inflight + w_fifo_count;
  assign w_credits     = credit_t'(RESP_DEPTH) - w_used;
  assign w_rd_eligible = i_rd_valid && (w_credits != '0);

  always_comb begin
    w_grant = GNT_NONE;
    if (i_reset) begin
      w_grant = GNT_NONE;
    end else if (i_wr_valid && w_rd_eligible) begin
      w_grant = (r_rr_last == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (i_wr_valid) begin
      w_grant = GNT_WR;
    end else if (w_rd_eligible) begin
      w_grant = GNT_RD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_last     <= GNT_RD;
      r_inflight_sr <= '0;
    end else begin
      if (w_grant != GNT_NONE) r_rr_last <= w_grant;
      r_inflight_sr[0] <= (w_grant == GNT_RD);
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_inflight_sr[i] <= r_inflight_sr[i-1];
      end
    end
  end

  assign o_wr_ready     = (w_grant == GNT_WR);
  assign o_rd_ready     = (w_grant == GNT_RD);
  assign o_mem_ce0      = (w_grant != GNT_NONE);
  assign o_mem_we0      = (w_grant == GNT_WR);
  assign o_mem_address0 = (w_grant == GNT_WR) ? i_wr_addr :
                          (w_grant == GNT_RD) ? i_rd_addr : '0;
  assign o_mem_d0       = (w_grant == GNT_WR) ? i_wr_data : '0;

  assign w_push = r_inflight_sr[MEM_LATENCY-1];
  assign w_pop  = o_resp_valid && i_resp_ready;

  knn_uram_resp_fifo #(
    .DataWidth (DataWidth),
    .Depth     (RESP_DEPTH)
  ) u_resp_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (i_mem_q0),
    .i_pop   (w_pop),
    .o_valid (o_resp_valid),
    .o_data  (o_resp_data),
    .o_count (w_fifo_count)
  );

  assign o_busy = (|r_inflight_sr) || (w_fifo_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) assert (w_used <= credit_t'(RESP_DEPTH));
  end

endmodule

// File: tb/tb_knn_local_uram_port_arbiter.sv
// Self-checking bench: URAM behavioural model plus a transaction-level scoreboard of grants,
// outstanding reads and response timing, with directed tables and randomized traffic.
module tb_knn_local_uram_port_arbiter;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrValid, wrReady, rdValid, rdReady;
  logic [AW-1:0] wrAddr, rdAddr, memAddr;
  logic [DW-1:0] wrData, respData, memD, memQ;
  logic          respValid, respReady, memCe, memWe, busy;

  always #5 clk = ~clk;

  knn_local_uram_port_arbiter dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wr_valid     (wrValid),
    .o_wr_ready     (wrReady),
    .i_wr_addr      (wrAddr),
    .i_wr_data      (wrData),
    .i_rd_valid     (rdValid),
    .o_rd_ready     (rdReady),
    .i_rd_addr      (rdAddr),
    .o_resp_valid   (respValid),
    .i_resp_ready   (respReady),
    .o_resp_data    (respData),
    .o_mem_address0 (memAddr),
    .o_mem_ce0      (memCe),
    .o_mem_we0      (memWe),
    .o_mem_d0       (memD),
    .i_mem_q0       (memQ),
    .o_busy         (busy)
  );

  // URAM with a two-cycle read pipeline.
  logic [DW-1:0] uram [0:(1<<AW)-1];
  logic [DW-1:0] qStage, qOut;
  always @(posedge clk) begin
    if (memCe && memWe) uram[memAddr] <= memD;
    qStage <= uram[memAddr];
    qOut   <= qStage;
  end
  assign memQ = qOut;

  typedef struct {
    logic [DW-1:0] data;
    int            cycle;
  } pend_t;

  typedef struct {
    bit wv;
    bit rv;
    bit rr;
    bit expW;
    bit expR;
  } vec_t;

  pend_t         pending[$];
  pend_t         popped[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            lastWasWrite;
  int            cycle;
  int            compared;
  int            mismatched;
  bit            lastWrReady, lastRdReady, lastRespValid, lastBusy;
  vec_t          vecs[10];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus: check outputs against the scoreboard, then advance it at the edge.
  task automatic applyStimulus(input bit rst, input bit wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input bit rv,
                               input logic [AW-1:0] ra, input bit rr);
    bit    rdElig, expWr, expRd, expRespValid;
    pend_t p;
    reset = rst; wrValid = wv; wrAddr = wa; wrData = wd;
    rdValid = rv; rdAddr = ra; respReady = rr;
    @(negedge clk);
    rdElig = rv && (pending.size() < DEPTH);
    expWr = 1'b0;
    expRd = 1'b0;
    if (!rst) begin
      if (wv && rdElig) begin
        expWr = !lastWasWrite;
        expRd = lastWasWrite;
      end else if (wv) begin
        expWr = 1'b1;
      end else if (rdElig) begin
        expRd = 1'b1;
      end
    end
    expRespValid = (pending.size() > 0) && (cycle >= pending[0].cycle);
    checkOutput("grant", DW'({wrReady, rdReady, memCe, memWe}),
                DW'({expWr, expRd, expWr | expRd, expWr}));
    if (expWr || expRd) checkOutput("addr", DW'(memAddr), DW'(expWr ? wa : ra));
    checkOutput("d0", memD, expWr ? wd : '0);
    checkOutput("respValid", DW'(respValid), DW'(expRespValid));
    checkOutput("busy", DW'(busy), DW'(pending.size() != 0));
    if (expRespValid) checkOutput("respData", respData, pending[0].data);
    lastWrReady   = wrReady;
    lastRdReady   = rdReady;
    lastRespValid = respValid;
    lastBusy      = busy;
    if (!rst && respValid && rr) begin
      p.data  = respData;
      p.cycle = cycle;
      popped.push_back(p);
    end
    @(posedge clk);
    if (rst) begin
      pending.delete();
      lastWasWrite = 1'b0;
    end else begin
      if (expRespValid && rr) void'(pending.pop_front());
      if (expWr) begin
        shadow[wa]   = wd;
        lastWasWrite = 1'b1;
      end
      if (expRd) begin
        p.data  = shadow[ra];
        p.cycle = cycle + LAT + 1;
        pending.push_back(p);
        lastWasWrite = 1'b0;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, rr);
  endtask

  initial begin
    int firstAccept, reqLeft;
    compared = 0; mismatched = 0; cycle = 0; lastWasWrite = 1'b0;
    reset = 1'b1; wrValid = 1'b1; rdValid = 1'b1; respReady = 1'b1;
    wrAddr = '0; rdAddr = '0; wrData = '0;
    @(posedge clk);
    #1;

    // Reset held with both requesters active.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, AW'(i), randData(), 1'b1, AW'(i), 1'b1);

    // Fill words 0..7, then stream them back.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, AW'(i), DW'(32'hA0 + i), 1'b0, '0, 1'b1);
    popped.delete();
    firstAccept = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
      if (lastRdReady && firstAccept < 0) firstAccept = cycle - 1;
    end
    idle(6, 1'b1);
    checkOutput("streamCount", DW'(popped.size()), DW'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < popped.size()) checkOutput("streamData", popped[i].data, DW'(32'hA0 + i));
    end
    if (popped.size() == 8) begin
      checkOutput("firstLatency", DW'(popped[0].cycle - firstAccept), DW'(3));
      checkOutput("streamSpan", DW'(popped[7].cycle - popped[0].cycle), DW'(7));
    end

    // Round-robin table, starting from a fresh reset.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    idle(4, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, vecs[k].wv, AW'(k % 8), randData(), vecs[k].rv, AW'((k + 3) % 8), vecs[k].rr);
      checkOutput("tblWrReady", DW'(lastWrReady), DW'(vecs[k].expW));
      checkOutput("tblRdReady", DW'(lastRdReady), DW'(vecs[k].expR));
    end
    idle(6, 1'b1);

    // Stalled reader: only four reads fit, writes keep flowing.
    popped.delete();
    reqLeft = 10;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, c >= 8, AW'(8 + c), randData(), reqLeft > 0, AW'((10 - reqLeft) % 8), 1'b0);
      if (lastRdReady) reqLeft--;
      if (c >= 8) checkOutput("stallWrite", DW'(lastWrReady), DW'(1));
    end
    checkOutput("stallAccepted", DW'(10 - reqLeft), DW'(4));
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, reqLeft > 0, AW'((10 - reqLeft) % 8), 1'b1);
      if (lastRdReady) reqLeft--;
    end
    checkOutput("releaseCount", DW'(popped.size()), DW'(10));

    // Read immediately after a write to the same word.
    popped.delete();
    applyStimulus(1'b0, 1'b1, AW'(5), DW'(32'h55), 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b1);
    idle(8, 1'b1);
    checkOutput("rawData", (popped.size() > 0) ? popped[0].data : '0, DW'(32'h55));

    // Reset with two reads in flight and two buffered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
    checkOutput("preResetBusy", DW'(lastBusy), DW'(1));
    popped.delete();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      checkOutput("postResetValid", DW'(lastRespValid), DW'(0));
      checkOutput("postResetBusy", DW'(lastBusy), DW'(0));
    end
    checkOutput("postResetPops", DW'(popped.size()), DW'(0));

    // Randomized mixed traffic over the already-written words.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    randData(), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0);
    end
    idle(8, 1'b1);
    checkOutput("finalIdle", DW'(lastBusy), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
